// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating counters.
// IF gets a zero-latency next-PC prediction. ID returns the resolved outcome.
// The block flags mispredicts, supplies the redirect PC and keeps branch
// statistics.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid_i,
  input  logic [XLEN-1:0]   pred_pc_i,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [XLEN-1:0]   upd_pred_target_i,
  input  logic              inv_i,
  output logic              mispredict_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int unsigned N_ENT = ENTRIES;
  localparam logic [CNT_W-1:0] CTR_WEAK = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CTR_RST  = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CTR_MAX  = '1;

  // Table storage
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [CNT_W-1:0]   r_ctr    [ENTRIES];

  logic [STAT_W-1:0]  r_branch_cnt;
  logic [STAT_W-1:0]  r_mispred_cnt;

  logic [IDX_W-1:0]   w_pidx;
  logic [TAG_W-1:0]   w_ptag;
  logic               w_phit;
  logic [IDX_W-1:0]   w_uidx;
  logic [TAG_W-1:0]   w_utag;
  logic               w_uhit;
  logic [XLEN-1:0]    w_upd_next;

  assign w_pidx = pred_pc_i[IDX_W+1:2];
  assign w_ptag = pred_pc_i[IDX_W+2 +: TAG_W];
  assign w_uidx = upd_pc_i[IDX_W+1:2];
  assign w_utag = upd_pc_i[IDX_W+2 +: TAG_W];

  // Lookup: combinational read of pre-edge table contents
  always_comb begin
    w_phit        = pred_valid_i & r_valid[w_pidx] & (r_tag[w_pidx] == w_ptag);
    pred_taken_o  = w_phit & r_ctr[w_pidx][CNT_W-1];
    pred_target_o = pred_taken_o ? r_target[w_pidx] : pred_pc_i + XLEN'(4);
  end

  // Resolution: correct next PC and mispredict flag, zero when idle
  always_comb begin
    w_uhit        = r_valid[w_uidx] & (r_tag[w_uidx] == w_utag);
    w_upd_next    = upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4);
    redirect_pc_o = upd_valid_i ? w_upd_next : '0;
    mispredict_o  = upd_valid_i & (upd_pred_target_i != w_upd_next);
  end

  // Table maintenance: reset > invalidate > update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < N_ENT; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RST;
      end
    end else if (inv_i) begin
      r_valid <= '0;
    end else if (upd_valid_i) begin
      if (w_uhit) begin
        if (upd_taken_i) begin
          if (r_ctr[w_uidx] != CTR_MAX) r_ctr[w_uidx] <= r_ctr[w_uidx] + CNT_W'(1);
          r_target[w_uidx] <= upd_target_i;
        end else if (r_ctr[w_uidx] != '0) begin
          r_ctr[w_uidx] <= r_ctr[w_uidx] - CNT_W'(1);
        end
      end else if (upd_taken_i) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= upd_target_i;
        r_ctr[w_uidx]    <= CTR_WEAK;
      end
    end
  end

  // Statistics count every resolved branch, even while invalidating
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (upd_valid_i) begin
      r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if (mispredict_o) r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
    end
  end

  assign branch_cnt_o  = r_branch_cnt;
  assign mispred_cnt_o = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default parameters:
// idx = pc[7:2], tag = pc[15:8]).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid_i;
  logic [31:0] pred_pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        inv_i;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_W(8), .CNT_W(2), .STAT_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .pred_valid_i      (pred_valid_i),
    .pred_pc_i         (pred_pc_i),
    .pred_taken_o      (pred_taken_o),
    .pred_target_o     (pred_target_o),
    .upd_valid_i       (upd_valid_i),
    .upd_pc_i          (upd_pc_i),
    .upd_taken_i       (upd_taken_i),
    .upd_target_i      (upd_target_i),
    .upd_pred_taken_i  (upd_pred_taken_i),
    .upd_pred_target_i (upd_pred_target_i),
    .inv_i             (inv_i),
    .mispredict_o      (mispredict_o),
    .redirect_pc_o     (redirect_pc_o),
    .branch_cnt_o      (branch_cnt_o),
    .mispred_cnt_o     (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    pred_valid_i = 1'b1;
    pred_pc_i    = pc;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt);
    upd_valid_i       = 1'b1;
    upd_pc_i          = pc;
    upd_taken_i       = tk;
    upd_target_i      = tgt;
    upd_pred_taken_i  = ptk;
    upd_pred_target_i = ptgt;
    #1;
  endtask

  task automatic idle();
    upd_valid_i = 1'b0;
    #1;
  endtask

  // one clocked update, then return to idle
  task automatic upd_step(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    upd(pc, tk, tgt, ptk, ptgt);
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1; pred_valid_i = 1'b0; pred_pc_i = '0; upd_valid_i = 1'b0;
    upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0; upd_pred_taken_i = 1'b0;
    upd_pred_target_i = '0; inv_i = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // 1: post-reset lookup
    lookup(32'h100);
    chk("rst_taken",  pred_taken_o, 0);
    chk("rst_target", pred_target_o, 32'h104);
    chk("rst_bcnt",   branch_cnt_o, 0);
    chk("rst_mcnt",   mispred_cnt_o, 0);
    chk("idle_misp",  mispredict_o, 0);
    chk("idle_redir", redirect_pc_o, 0);

    // 2: first taken branch allocates; same-cycle lookup sees old (empty) entry
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    chk("alloc_misp",   mispredict_o, 1);
    chk("alloc_redir",  redirect_pc_o, 32'h80);
    chk("nobypass_tk",  pred_taken_o, 0);
    chk("nobypass_tgt", pred_target_o, 32'h104);
    tick(); idle();
    chk("alloc_tk",   pred_taken_o, 1);
    chk("alloc_tgt",  pred_target_o, 32'h80);
    chk("alloc_bcnt", branch_cnt_o, 1);
    chk("alloc_mcnt", mispred_cnt_o, 1);

    // 3: saturation toward 0 (ctr 2 -> 1 -> 0 -> 0)
    upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h104);
    chk("nt_misp",  mispredict_o, 0);
    chk("nt_redir", redirect_pc_o, 32'h104);
    tick(); idle();
    chk("ctr1_tk",  pred_taken_o, 0);
    chk("ctr1_tgt", pred_target_o, 32'h104);
    upd_step(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    upd_step(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    chk("ctr0_tk", pred_taken_o, 0);
    // climb back: 0 -> 1 stays not-taken, proving no wrap at 0
    upd_step(32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
    chk("ctr0to1_tk", pred_taken_o, 0);
    upd_step(32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
    chk("ctr2_tk", pred_taken_o, 1);
    upd_step(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    upd_step(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    chk("ctr3_tk", pred_taken_o, 1);
    // one not-taken from saturated 3 -> 2, still taken (no wrap at max)
    upd_step(32'h100, 1'b0, 32'h80, 1'b1, 32'h104);
    chk("ctrmax_nt_tk",  pred_taken_o, 1);
    chk("ctrmax_nt_tgt", pred_target_o, 32'h80);
    chk("sat_bcnt", branch_cnt_o, 9);
    chk("sat_mcnt", mispred_cnt_o, 1);

    // 4: aliasing replaces the entry at idx 0
    upd(32'h1100, 1'b1, 32'h200, 1'b0, 32'h1104);
    chk("alias_misp", mispredict_o, 1);
    tick(); idle();
    lookup(32'h1100);
    chk("alias_tgt", pred_target_o, 32'h200);
    lookup(32'h100);
    chk("alias_old_tk",  pred_taken_o, 0);
    chk("alias_old_tgt", pred_target_o, 32'h104);
    upd_step(32'h2100, 1'b0, 32'h300, 1'b0, 32'h2104);
    lookup(32'h1100);
    chk("ntmiss_tk",  pred_taken_o, 1);
    chk("ntmiss_tgt", pred_target_o, 32'h200);
    chk("alias_bcnt", branch_cnt_o, 11);
    chk("alias_mcnt", mispred_cnt_o, 2);

    // 5: direction right, target wrong
    upd(32'h1100, 1'b1, 32'h90, 1'b1, 32'h200);
    chk("tgt_misp",  mispredict_o, 1);
    chk("tgt_redir", redirect_pc_o, 32'h90);
    tick(); idle();
    chk("tgt_new", pred_target_o, 32'h90);
    pred_valid_i = 1'b0; #1;
    chk("noval_tk",  pred_taken_o, 0);
    chk("noval_tgt", pred_target_o, 32'h1104);
    lookup(32'hFFFF_FFFC);
    chk("wrap_tgt", pred_target_o, 32'h0);

    // 6a: same-cycle lookup and update
    lookup(32'h1100);
    upd(32'h1100, 1'b1, 32'hA0, 1'b1, 32'h90);
    chk("same_old_tgt", pred_target_o, 32'h90);
    tick(); idle();
    chk("same_new_tgt", pred_target_o, 32'hA0);

    // 6b: invalidate with a taken update; update dropped, stats still count
    inv_i = 1'b1;
    upd(32'h300, 1'b1, 32'h400, 1'b0, 32'h304);
    chk("inv_misp", mispredict_o, 1);
    tick(); idle(); inv_i = 1'b0; #1;
    chk("inv_tk",  pred_taken_o, 0);
    chk("inv_tgt", pred_target_o, 32'h1104);
    lookup(32'h300);
    chk("inv_drop_tk", pred_taken_o, 0);
    chk("inv_bcnt", branch_cnt_o, 14);
    chk("inv_mcnt", mispred_cnt_o, 5);

    // 6c: reset with a concurrent update
    rst = 1'b1;
    upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick(); idle(); rst = 1'b0;
    lookup(32'h100);
    chk("rst2_tk",   pred_taken_o, 0);
    chk("rst2_tgt",  pred_target_o, 32'h104);
    chk("rst2_bcnt", branch_cnt_o, 0);
    chk("rst2_mcnt", mispred_cnt_o, 0);
    chk("rst2_misp", mispredict_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
